// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo front end.
// Defines the decoded op code and the control word carried from decode to dispatch.
package tomasula_types;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLT,
        OP_SLL,
        OP_SRL,
        OP_BR,
        OP_LD,
        OP_ST
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [4:0] dest_reg;
        logic [4:0] src1_reg;
        logic [4:0] src2_reg;
        logic [15:0] imm;
    } ctl_word;

endpackage

// File: rtl/issue_dispatch_q_if.sv
// Bundle between decode, the issue/dispatch queue and the RS/ROB/LSQ side.
// slave: the queue (enq/stall inputs in, strobes/head out); master: the environment.
interface issue_dispatch_q_if #(
    parameter int NUM_RS = 4,
    parameter int CNT_W  = 4
);
    import tomasula_types::*;

    logic              flush_i;
    logic              enq_valid_i;
    ctl_word           enq_ctl_i;
    logic              enq_ready_o;
    logic              enq_ack_o;
    logic [NUM_RS-1:0] rs_empty_i;
    logic [NUM_RS-1:0] rs_load_o;
    logic              ldst_rs_empty_i;
    logic              ldst_q_full_i;
    logic              ldst_load_o;
    logic              rob_full_i;
    logic              rob_load_o;
    logic [4:0]        regfile_tag1_o;
    logic [4:0]        regfile_tag2_o;
    ctl_word           ctl_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  flush_i, enq_valid_i, enq_ctl_i,
        input  rs_empty_i, ldst_rs_empty_i, ldst_q_full_i, rob_full_i,
        output enq_ready_o, enq_ack_o, rs_load_o, ldst_load_o,
        output rob_load_o, regfile_tag1_o, regfile_tag2_o, ctl_o, count_o
    );

    modport master (
        output flush_i, enq_valid_i, enq_ctl_i,
        output rs_empty_i, ldst_rs_empty_i, ldst_q_full_i, rob_full_i,
        input  enq_ready_o, enq_ack_o, rs_load_o, ldst_load_o,
        input  rob_load_o, regfile_tag1_o, regfile_tag2_o, ctl_o, count_o
    );

endinterface

// File: rtl/issue_dispatch_q.sv
// In-order issue queue: buffers decoded words, dispatches the head to an ALU RS
// (round-robin) or the LD/ST RS. Ports: clk, rst (sync, active-high), q (slave bundle).
module issue_dispatch_q
    import tomasula_types::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_RS = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic               clk,
    input logic               rst,
    issue_dispatch_q_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int RR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    ctl_word          mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [RR_W-1:0]  rr_ptr;

    logic [RR_W-1:0]  sel_idx;
    logic [RR_W-1:0]  cand;
    logic             sel_found;
    logic             head_valid;
    logic             is_ldst;
    logic             ldst_go;
    logic             alu_go;
    logic             deq;
    logic             acc;
    ctl_word          head_ctl;

    assign head_valid = (count != '0);
    assign head_ctl   = head_valid ? mem[head] : '0;
    assign is_ldst    = (head_ctl.op == OP_LD) || (head_ctl.op == OP_ST);

    // First empty station starting at rr_ptr, wrapping modulo NUM_RS.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            cand = RR_W'((int'(rr_ptr) + k) % NUM_RS);
            if (!sel_found && q.rs_empty_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign ldst_go = head_valid & is_ldst & q.ldst_rs_empty_i
                   & ~q.ldst_q_full_i & ~q.rob_full_i & ~q.flush_i;
    assign alu_go  = head_valid & ~is_ldst & sel_found
                   & ~q.rob_full_i & ~q.flush_i;
    assign deq     = ldst_go | alu_go;

    // Acceptance uses the start-of-cycle count, so a full queue never
    // refills in the cycle it dispatches.
    assign q.enq_ready_o = (count != CNT_W'(DEPTH));
    assign acc           = q.enq_valid_i & q.enq_ready_o & ~q.flush_i;
    assign q.enq_ack_o   = acc;

    assign q.rs_load_o      = alu_go ? (NUM_RS'(1) << sel_idx) : '0;
    assign q.ldst_load_o    = ldst_go;
    assign q.rob_load_o     = deq;
    assign q.ctl_o          = head_ctl;
    assign q.regfile_tag1_o = head_ctl.src1_reg;
    assign q.regfile_tag2_o = head_ctl.src2_reg;
    assign q.count_o        = count;

    always_ff @(posedge clk) begin
        if (!rst && acc) begin
            mem[tail] <= q.enq_ctl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else if (q.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (acc) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (alu_go) begin
                rr_ptr <= RR_W'((int'(sel_idx) + 1) % NUM_RS);
            end
            case ({acc, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_dispatch_q.sv
// Directed bench for issue_dispatch_q (DEPTH=8, NUM_RS=4).
// Drives on the falling edge, checks combinational outputs 1ns later.
module tb_issue_dispatch_q;
    import tomasula_types::*;

    localparam int DEPTH  = 8;
    localparam int NUM_RS = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    issue_dispatch_q_if #(.NUM_RS(NUM_RS), .CNT_W(CNT_W)) q ();

    issue_dispatch_q #(
        .DEPTH (DEPTH),
        .NUM_RS(NUM_RS),
        .CNT_W (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q  (q)
    );

    int n_chk  = 0;
    int n_pass = 0;

    ctl_word w [24];
    ctl_word v [20];
    ctl_word ld;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic ctl_word mk(input op_t op, input int i);
        ctl_word c;
        c.op       = op;
        c.dest_reg = 5'(i + 1);
        c.src1_reg = 5'(i + 2);
        c.src2_reg = 5'(i * 3 + 5);
        c.imm      = 16'(i * 7 + 1);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input ctl_word c);
        q.enq_valid_i = 1'b1;
        q.enq_ctl_i   = c;
        step();
        q.enq_valid_i = 1'b0;
    endtask

    initial begin
        q.flush_i         = 1'b0;
        q.enq_valid_i     = 1'b0;
        q.enq_ctl_i       = '0;
        q.rs_empty_i      = '0;
        q.ldst_rs_empty_i = 1'b0;
        q.ldst_q_full_i   = 1'b0;
        q.rob_full_i      = 1'b0;
        for (int i = 0; i < 24; i++) w[i] = mk(OP_ADD, i);
        for (int i = 0; i < 20; i++) v[i] = mk(OP_SUB, i + 30);
        ld = mk(OP_LD, 40);

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_count", 64'(q.count_o), 64'd0);
        check("rst_ready", 64'(q.enq_ready_o), 64'd1);
        check("rst_ack", 64'(q.enq_ack_o), 64'd0);
        check("rst_rs_load", 64'(q.rs_load_o), 64'd0);
        check("rst_ldst_load", 64'(q.ldst_load_o), 64'd0);
        check("rst_rob_load", 64'(q.rob_load_o), 64'd0);
        check("rst_ctl", 64'(q.ctl_o), 64'd0);
        check("rst_tag1", 64'(q.regfile_tag1_o), 64'd0);

        // Fill with all stations busy
        for (int i = 0; i < DEPTH; i++) begin
            q.enq_valid_i = 1'b1;
            q.enq_ctl_i   = w[i];
            #1;
            check("fill_ack", 64'(q.enq_ack_o), 64'd1);
            step();
        end
        q.enq_ctl_i = w[8];
        #1;
        check("full_count", 64'(q.count_o), 64'd8);
        check("full_ready", 64'(q.enq_ready_o), 64'd0);
        check("full_ack9", 64'(q.enq_ack_o), 64'd0);
        check("full_ctl", 64'(q.ctl_o), 64'(w[0]));
        check("full_tag1", 64'(q.regfile_tag1_o), 64'(w[0].src1_reg));
        check("full_tag2", 64'(q.regfile_tag2_o), 64'(w[0].src2_reg));

        // Full and dispatching: still no accept
        q.rs_empty_i = 4'b1111;
        #1;
        check("fulldq_ack", 64'(q.enq_ack_o), 64'd0);
        check("rr_load0", 64'(q.rs_load_o), 64'b0001);
        check("rr_rob0", 64'(q.rob_load_o), 64'd1);
        step();
        q.enq_valid_i = 1'b0;
        check("fulldq_count", 64'(q.count_o), 64'd7);

        // Round-robin drain
        for (int k = 1; k < DEPTH; k++) begin
            #1;
            check("rr_ctl", 64'(q.ctl_o), 64'(w[k]));
            check("rr_load", 64'(q.rs_load_o), 64'(1 << (k % 4)));
            check("rr_rob", 64'(q.rob_load_o), 64'd1);
            step();
        end
        #1;
        check("empty_count", 64'(q.count_o), 64'd0);
        check("empty_rs_load", 64'(q.rs_load_o), 64'd0);
        check("empty_rob", 64'(q.rob_load_o), 64'd0);
        check("empty_ctl", 64'(q.ctl_o), 64'd0);

        // Skip busy stations (set rr_ptr=1 first)
        q.rs_empty_i = 4'b0000;
        push(w[8]);
        q.rs_empty_i  = 4'b1111;
        q.enq_valid_i = 1'b1;
        q.enq_ctl_i   = w[9];
        #1;
        check("skip_pre_load", 64'(q.rs_load_o), 64'b0001);
        check("skip_pre_ack", 64'(q.enq_ack_o), 64'd1);
        step();
        q.enq_valid_i = 1'b0;
        q.rs_empty_i  = 4'b1001;
        #1;
        check("skip_ctl", 64'(q.ctl_o), 64'(w[9]));
        check("skip_load", 64'(q.rs_load_o), 64'b1000);
        step();
        q.rs_empty_i = 4'b0000;
        push(w[10]);
        q.rs_empty_i = 4'b1111;
        #1;
        check("skip_rr0", 64'(q.rs_load_o), 64'b0001);
        step();

        // LD stall behind a full LSQ; younger ALU op blocked
        q.rs_empty_i      = 4'b0000;
        q.ldst_rs_empty_i = 1'b1;
        q.ldst_q_full_i   = 1'b1;
        push(ld);
        q.rs_empty_i = 4'b1111;
        for (int s = 0; s < 3; s++) begin
            q.enq_valid_i = (s == 0);
            q.enq_ctl_i   = w[11];
            #1;
            check("ld_stall_ldst", 64'(q.ldst_load_o), 64'd0);
            check("ld_stall_rob", 64'(q.rob_load_o), 64'd0);
            check("ld_stall_rs", 64'(q.rs_load_o), 64'd0);
            step();
        end
        q.enq_valid_i   = 1'b0;
        q.ldst_q_full_i = 1'b0;
        #1;
        check("ld_go_ctl", 64'(q.ctl_o), 64'(ld));
        check("ld_go_ldst", 64'(q.ldst_load_o), 64'd1);
        check("ld_go_rob", 64'(q.rob_load_o), 64'd1);
        check("ld_go_rs", 64'(q.rs_load_o), 64'd0);
        step();
        #1;
        check("ld_next_ctl", 64'(q.ctl_o), 64'(w[11]));
        check("ld_next_rs", 64'(q.rs_load_o), 64'b0010);
        check("ld_next_ldst", 64'(q.ldst_load_o), 64'd0);
        step();

        // ROB back-pressure
        q.rs_empty_i = 4'b0000;
        push(w[12]);
        q.rs_empty_i = 4'b1111;
        q.rob_full_i = 1'b1;
        #1;
        check("rob_full_rs", 64'(q.rs_load_o), 64'd0);
        check("rob_full_rob", 64'(q.rob_load_o), 64'd0);
        step();
        check("rob_full_count", 64'(q.count_o), 64'd1);
        q.rob_full_i = 1'b0;
        #1;
        check("rob_rel_rs", 64'(q.rs_load_o), 64'b0100);
        step();

        // Flush against enqueue and a dispatchable head
        q.rs_empty_i = 4'b0000;
        for (int i = 13; i < 18; i++) push(w[i]);
        check("pre_flush_count", 64'(q.count_o), 64'd5);
        q.flush_i     = 1'b1;
        q.enq_valid_i = 1'b1;
        q.enq_ctl_i   = w[18];
        q.rs_empty_i  = 4'b1111;
        #1;
        check("flush_ack", 64'(q.enq_ack_o), 64'd0);
        check("flush_rs", 64'(q.rs_load_o), 64'd0);
        check("flush_rob", 64'(q.rob_load_o), 64'd0);
        check("flush_ldst", 64'(q.ldst_load_o), 64'd0);
        step();
        q.flush_i     = 1'b0;
        q.enq_valid_i = 1'b0;
        q.rs_empty_i  = 4'b0000;
        #1;
        check("post_flush_count", 64'(q.count_o), 64'd0);
        check("post_flush_ctl", 64'(q.ctl_o), 64'd0);
        push(w[19]);
        q.rs_empty_i = 4'b1111;
        #1;
        check("flush_rr_held", 64'(q.rs_load_o), 64'b1000);
        check("flush_new_ctl", 64'(q.ctl_o), 64'(w[19]));
        step();

        // Wrap-around: 20 push/pop pairs
        q.rs_empty_i = 4'b0000;
        push(v[0]);
        q.rs_empty_i = 4'b1111;
        for (int i = 1; i < 20; i++) begin
            q.enq_valid_i = 1'b1;
            q.enq_ctl_i   = v[i];
            #1;
            check("wrap_ctl", 64'(q.ctl_o), 64'(v[i-1]));
            check("wrap_ack", 64'(q.enq_ack_o), 64'd1);
            check("wrap_rs", 64'(q.rs_load_o), 64'(1 << ((i - 1) % 4)));
            step();
            check("wrap_count", 64'(q.count_o), 64'd1);
        end
        q.enq_valid_i = 1'b0;
        #1;
        check("wrap_last_ctl", 64'(q.ctl_o), 64'(v[19]));
        check("wrap_last_rs", 64'(q.rs_load_o), 64'b1000);
        step();
        check("wrap_end_count", 64'(q.count_o), 64'd0);

        // Reset mid-stream
        q.rs_empty_i = 4'b0000;
        push(w[20]);
        push(w[21]);
        check("mid_pre_count", 64'(q.count_o), 64'd2);
        rst           = 1'b1;
        q.enq_valid_i = 1'b1;
        q.enq_ctl_i   = w[22];
        step();
        rst           = 1'b0;
        q.enq_valid_i = 1'b0;
        #1;
        check("mid_rst_count", 64'(q.count_o), 64'd0);
        check("mid_rst_ctl", 64'(q.ctl_o), 64'd0);
        check("mid_rst_ready", 64'(q.enq_ready_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
